add16_resp_checker: RTL and testbench
=====================================

# add16_resp_checker

Self-checking response consumer for the 16-bit adder verification flow. It accepts (A, B, Cin, Sum, Cout) result vectors over a valid/ready handshake and recomputes the golden A+B+Cin. It counts vectors and mismatches, captures the first failing vector, and reports Done/Pass once a programmed number of vectors has been checked. It sits between the vector source driving the adder under test and the bench or FPGA status logic, replacing off-line comparison of the logged "A B Cin | Cout Sum" lines.

## Interface
Parameters:
- W, 16, operand/sum width
- CNT_W, 16, width of vector and error counters and of Expect_count

Ports:
- Clk  in  1  clock, all state changes on rising edge
- Reset_n  in  1  synchronous, active-low reset
- Start  in  1  one-cycle pulse: clear counters and captures, latch Expect_count, enter RUN
- Expect_count  in  CNT_W  number of vectors to check; sampled only when Start=1
- In_valid  in  1  result vector present
- In_ready  out  1  checker accepts a vector this cycle
- A, B  in  W  operands applied to the adder under test
- Cin  in  1  carry-in applied
- Sum  in  W  sum returned by the adder under test
- Cout  in  1  carry-out returned by the adder under test
- Vec_count  out  CNT_W  vectors compared so far
- Err_count  out  CNT_W  mismatching vectors, saturating
- Done  out  1  all Expect_count vectors compared
- Pass  out  1  Done and Err_count==0
- Fail_valid  out  1  a first-fail capture is held
- Fail_A, Fail_B  out  W  operands of the first failing vector
- Fail_Cin, Fail_Cout  out  1  Cin and observed Cout of the first failing vector
- Fail_Sum  out  W  observed Sum of the first failing vector

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE/DONE/RUN + Start=1 -> RUN, or DONE if Expect_count==0. Clears Vec_count, Err_count, accept counter, pipeline valids and Fail_* capture.
- RUN: In_ready = 1 while accepted count < latched Expect_count; otherwise 0. In IDLE and DONE, In_ready = 0.
- Accept = In_valid & In_ready. The vector is registered into stage 1 and the accept counter increments.
- Stage 2 compare: golden {Cout_g, Sum_g} = A + B + Cin, computed at W+1 bits. Mismatch = (Sum != Sum_g) | (Cout != Cout_g).
- On compare: Vec_count += 1. On a mismatch, Err_count += 1, saturating at 2^CNT_W-1.
- RUN -> DONE on the compare edge where Vec_count reaches the latched Expect_count.
- Done = (state==DONE). Pass = Done & (Err_count==0).
- A Start pulse in RUN restarts the run: the in-flight stage-1 vector is discarded, not compared.
- Start has priority over a compare on the same edge.
- In_valid is ignored when In_ready=0. Source data need not be held stable beyond the accept cycle.

## Timing
- Reset: all outputs 0 (In_ready 0, counters 0, Done 0, Pass 0, Fail_* 0), state IDLE, one edge after Reset_n sampled low.
- Reset_n low mid-run aborts immediately. No partial results are retained.
- Latency: vector accepted at edge k is reflected in Vec_count/Err_count/Fail_* after edge k+1.
- Done for the last vector is visible after the same edge k+1.
- Throughput is one vector per cycle. No bubbles are required between accepts.
- In_ready falls after the edge accepting vector number Expect_count.
- Start with Expect_count==0: Done=1, Pass=1 after that edge.

## Configuration
- CHK_FIRST_FAIL_EN defined: the first mismatch after Start loads all Fail_* registers and sets Fail_valid. Later mismatches do not overwrite them until the next Start or reset.
- CHK_FIRST_FAIL_EN undefined: no capture registers are built. Fail_valid and all Fail_* outputs are constant 0. Counting, Done and Pass are unchanged.

## Test plan
- Reset: hold Reset_n=0 for 2 cycles with In_valid=1 -> all outputs 0, no accepts, state IDLE.
- Clean run: Start with Expect_count=3, then back-to-back vectors:
  - (0x0001, 0x0001, 0 | Sum 0x0002, Cout 0)
  - (0xFFFF, 0x0001, 0 | 0x0000, 1)
  - (0x8000, 0x8000, 1 | 0x0001, 1)
  - Required response: Done and Pass rise one cycle after the third accept; Vec_count=3, Err_count=0.
- Error capture (CHK_FIRST_FAIL_EN): Expect_count=2.
  - Vector 1: (0x1234, 0x1111, 1 | Sum 0x2345, Cout 0); the correct sum is 0x2346.
  - Vector 2: (0x0000, 0x0000, 0 | Sum 0x0001, Cout 0).
  - Required response: Err_count=2, Pass=0, Fail_valid=1, Fail_A=0x1234, Fail_B=0x1111, Fail_Cin=1, Fail_Sum=0x2345, Fail_Cout=0.
- Handshake: Expect_count=3, In_valid held high for 5 cycles with gaps before the first accept -> exactly 3 accepts, In_ready=0 from the 4th cycle on, Vec_count stops at 3.
- Zero-length and restart:
  - Start with Expect_count=0 -> Done=1, Pass=1 next cycle.
  - Start with Expect_count=4, accept 2 vectors, pulse Start again with Expect_count=1 -> Vec_count=0 and Fail_valid=0 after the pulse, and one further vector completes the run.
- Reset mid-run: after 1 accept of a failing vector, drive Reset_n=0 for 1 cycle -> Err_count=0, Fail_valid=0, state IDLE; a following Start runs normally.

Source files
------------

// File: rtl/add16_resp_checker.sv
// Response checker for the 16-bit adder flow: recomputes A+B+Cin, counts vectors/mismatches, reports Done/Pass.
// Optional first-fail capture registers are built when CHK_FIRST_FAIL_EN is defined.
module add16_resp_checker #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [CNT_W-1:0] Expect_count,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic             Cin,
  input  logic [W-1:0]     Sum,
  input  logic             Cout,
  output logic [CNT_W-1:0] Vec_count,
  output logic [CNT_W-1:0] Err_count,
  output logic             Done,
  output logic             Pass,
  output logic             Fail_valid,
  output logic [W-1:0]     Fail_A,
  output logic [W-1:0]     Fail_B,
  output logic             Fail_Cin,
  output logic             Fail_Cout,
  output logic [W-1:0]     Fail_Sum
);

  // state  | meaning
  // IDLE   | after reset, waiting for Start
  // RUN    | accepting and comparing vectors
  // DONE   | Expect_count vectors compared, Done/Pass valid
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] exp_q;
  logic [CNT_W-1:0] acc_cnt_q;
  logic [CNT_W-1:0] vec_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic             s1_valid_q;
  logic [W-1:0]     s1_a_q, s1_b_q, s1_sum_q;
  logic             s1_cin_q, s1_cout_q;

  logic             accept;
  logic [W:0]       golden;
  logic             mismatch;
  logic             cmp_last;

  assign In_ready = (state_q == S_RUN) && (acc_cnt_q < exp_q);
  // Start wins: a vector offered on the Start edge belongs to the aborted run.
  assign accept   = In_valid && In_ready && !Start;

  assign golden   = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{W{1'b0}}, s1_cin_q};
  assign mismatch = ({s1_cout_q, s1_sum_q} != golden);
  assign cmp_last = s1_valid_q && ((vec_cnt_q + CNT_W'(1)) == exp_q);

  always_comb begin
    state_d = state_q;
    if (Start) begin
      state_d = (Expect_count == '0) ? S_DONE : S_RUN;
    end else if ((state_q == S_RUN) && cmp_last) begin
      state_d = S_DONE;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      exp_q      <= '0;
      acc_cnt_q  <= '0;
      vec_cnt_q  <= '0;
      err_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (Start) begin
        exp_q      <= Expect_count;
        acc_cnt_q  <= '0;
        vec_cnt_q  <= '0;
        err_cnt_q  <= '0;
        s1_valid_q <= 1'b0;
      end else begin
        s1_valid_q <= accept;
        if (accept) begin
          acc_cnt_q <= acc_cnt_q + CNT_W'(1);
        end
        if (s1_valid_q) begin
          vec_cnt_q <= vec_cnt_q + CNT_W'(1);
          if (mismatch && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
          end
        end
      end
    end
  end

  // Stage-1 payload is qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge Clk) begin
    if (accept) begin
      s1_a_q    <= A;
      s1_b_q    <= B;
      s1_cin_q  <= Cin;
      s1_sum_q  <= Sum;
      s1_cout_q <= Cout;
    end
  end

  assign Vec_count = vec_cnt_q;
  assign Err_count = err_cnt_q;
  assign Done      = (state_q == S_DONE);
  assign Pass      = Done && (err_cnt_q == '0);

`ifdef CHK_FIRST_FAIL_EN
  logic         fail_valid_q;
  logic [W-1:0] fail_a_q, fail_b_q, fail_sum_q;
  logic         fail_cin_q, fail_cout_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n || Start) begin
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_sum_q   <= '0;
      fail_cin_q   <= 1'b0;
      fail_cout_q  <= 1'b0;
    end else if (s1_valid_q && mismatch && !fail_valid_q) begin
      fail_valid_q <= 1'b1;
      fail_a_q     <= s1_a_q;
      fail_b_q     <= s1_b_q;
      fail_sum_q   <= s1_sum_q;
      fail_cin_q   <= s1_cin_q;
      fail_cout_q  <= s1_cout_q;
    end
  end

  assign Fail_valid = fail_valid_q;
  assign Fail_A     = fail_a_q;
  assign Fail_B     = fail_b_q;
  assign Fail_Cin   = fail_cin_q;
  assign Fail_Cout  = fail_cout_q;
  assign Fail_Sum   = fail_sum_q;
`else
  assign Fail_valid = 1'b0;
  assign Fail_A     = '0;
  assign Fail_B     = '0;
  assign Fail_Cin   = 1'b0;
  assign Fail_Cout  = 1'b0;
  assign Fail_Sum   = '0;
`endif

endmodule

// File: tb/tb_add16_resp_checker.sv
// Bench for add16_resp_checker: queue-based reference model checked every cycle plus directed literal checks.
module tb_add16_resp_checker;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic [15:0] Expect_count = '0;
  logic        In_valid = 1'b0;
  logic        In_ready;
  logic [15:0] A = '0, B = '0, Sum = '0;
  logic        Cin = 1'b0, Cout = 1'b0;
  logic [15:0] Vec_count, Err_count;
  logic        Done, Pass, Fail_valid, Fail_Cin, Fail_Cout;
  logic [15:0] Fail_A, Fail_B, Fail_Sum;

  add16_resp_checker #(.W(16), .CNT_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Expect_count(Expect_count),
    .In_valid(In_valid), .In_ready(In_ready), .A(A), .B(B), .Cin(Cin),
    .Sum(Sum), .Cout(Cout), .Vec_count(Vec_count), .Err_count(Err_count),
    .Done(Done), .Pass(Pass), .Fail_valid(Fail_valid), .Fail_A(Fail_A),
    .Fail_B(Fail_B), .Fail_Cin(Fail_Cin), .Fail_Cout(Fail_Cout), .Fail_Sum(Fail_Sum)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run mode, counts and a queue of vectors awaiting comparison.
  localparam int MI = 0, MR = 1, MD = 2;
  typedef struct packed {
    logic [15:0] a, b, s;
    logic        ci, co;
  } vec_t;

  vec_t        pend[$];
  int          m_mode = MI;
  bit          m_armed = 0;
  logic [15:0] m_exp = '0, m_acc = '0, m_vec = '0, m_err = '0;
  logic        m_fv = 1'b0, m_fci = 1'b0, m_fco = 1'b0;
  logic [15:0] m_fa = '0, m_fb = '0, m_fs = '0;

  function automatic bit wrong(input vec_t v);
    int t;
    t = int'(v.a) + int'(v.b) + int'(v.ci);
    return (int'({v.co, v.s}) != t);
  endfunction

  function automatic bit m_ready();
    return (m_mode == MR) && (m_acc < m_exp);
  endfunction

  task automatic m_clear();
    m_acc = '0; m_vec = '0; m_err = '0;
    m_fv = 0; m_fa = '0; m_fb = '0; m_fs = '0; m_fci = 0; m_fco = 0;
    pend.delete();
  endtask

  always @(posedge Clk) begin
    bit   rdy;
    vec_t v;
    rdy = m_ready();
    if (!Reset_n) begin
      m_armed = 1;
      m_mode  = MI;
      m_exp   = '0;
      m_clear();
    end else if (Start) begin
      m_clear();
      m_exp  = Expect_count;
      m_mode = (Expect_count == 0) ? MD : MR;
    end else begin
      if (pend.size() > 0) begin
        v = pend.pop_front();
        m_vec++;
        if (wrong(v)) begin
          if (m_err != 16'hFFFF) m_err++;
`ifdef CHK_FIRST_FAIL_EN
          if (!m_fv) begin
            m_fv = 1; m_fa = v.a; m_fb = v.b; m_fs = v.s; m_fci = v.ci; m_fco = v.co;
          end
`endif
        end
        if (m_vec == m_exp) m_mode = MD;
      end
      if (rdy && In_valid) begin
        v = '{a: A, b: B, s: Sum, ci: Cin, co: Cout};
        pend.push_back(v);
        m_acc++;
      end
    end
  end

  always @(negedge Clk) begin
    if (m_armed) begin
      chk("in_ready",   In_ready,   m_ready());
      chk("vec_count",  Vec_count,  m_vec);
      chk("err_count",  Err_count,  m_err);
      chk("done",       Done,       m_mode == MD);
      chk("pass",       Pass,       (m_mode == MD) && (m_err == 0));
      chk("fail_valid", Fail_valid, m_fv);
      chk("fail_a",     Fail_A,     m_fa);
      chk("fail_b",     Fail_B,     m_fb);
      chk("fail_sum",   Fail_Sum,   m_fs);
      chk("fail_cin",   Fail_Cin,   m_fci);
      chk("fail_cout",  Fail_Cout,  m_fco);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [15:0] a, input logic [15:0] b,
                     input logic ci, input logic [15:0] s, input logic co);
    In_valid = v; A = a; B = b; Cin = ci; Sum = s; Cout = co;
    tick();
  endtask

  task automatic idle();
    drv(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic start(input logic [15:0] n);
    In_valid = 1'b0; Start = 1'b1; Expect_count = n;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    // Reset with In_valid asserted.
    Reset_n = 1'b0;
    drv(1'b1, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);
    drv(1'b1, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);
    chk("lit_rst_ready", In_ready, 0);
    chk("lit_rst_vec",   Vec_count, 0);
    chk("lit_rst_done",  Done, 0);
    chk("lit_rst_pass",  Pass, 0);
    Reset_n = 1'b1;
    idle();

    // Clean run, back-to-back.
    start(16'd3);
    drv(1'b1, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
    drv(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    drv(1'b1, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);
    chk("lit_clean_done_early", Done, 0);
    chk("lit_clean_ready_low", In_ready, 0);
    idle();
    chk("lit_clean_done", Done, 1);
    chk("lit_clean_pass", Pass, 1);
    chk("lit_clean_vec",  Vec_count, 3);
    chk("lit_clean_err",  Err_count, 0);

    // Two failing vectors; only the first is captured.
    start(16'd2);
    drv(1'b1, 16'h1234, 16'h1111, 1'b1, 16'h2345, 1'b0);
    drv(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0001, 1'b0);
    idle();
    chk("lit_err_count", Err_count, 2);
    chk("lit_err_done",  Done, 1);
    chk("lit_err_pass",  Pass, 0);
`ifdef CHK_FIRST_FAIL_EN
    chk("lit_err_fv",   Fail_valid, 1);
    chk("lit_err_fa",   Fail_A, 16'h1234);
    chk("lit_err_fb",   Fail_B, 16'h1111);
    chk("lit_err_fcin", Fail_Cin, 1);
    chk("lit_err_fsum", Fail_Sum, 16'h2345);
    chk("lit_err_fco",  Fail_Cout, 0);
`else
    chk("lit_err_fv",   Fail_valid, 0);
    chk("lit_err_fa",   Fail_A, 0);
`endif

    // Handshake: gaps, then In_valid held for 5 cycles.
    start(16'd3);
    idle();
    idle();
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 16'h0005 + 16'(i), 16'h0006, 1'b0, 16'h000B + 16'(i), 1'b0);
      if (i == 2) chk("lit_hs_ready_off", In_ready, 0);
    end
    idle();
    chk("lit_hs_vec",  Vec_count, 3);
    chk("lit_hs_pass", Pass, 1);

    // Zero-length run.
    start(16'd0);
    chk("lit_zero_done", Done, 1);
    chk("lit_zero_pass", Pass, 1);
    chk("lit_zero_ready", In_ready, 0);

    // Restart with a vector in flight.
    start(16'd4);
    drv(1'b1, 16'h0010, 16'h0020, 1'b0, 16'h0031, 1'b0);
    drv(1'b1, 16'h0100, 16'h0200, 1'b0, 16'h0399, 1'b0);
    Start = 1'b1; Expect_count = 16'd1; In_valid = 1'b0;
    tick();
    Start = 1'b0;
    chk("lit_rs_vec", Vec_count, 0);
    chk("lit_rs_err", Err_count, 0);
    chk("lit_rs_fv",  Fail_valid, 0);
    idle();
    chk("lit_rs_vec_discard", Vec_count, 0);
    drv(1'b1, 16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0);
    idle();
    chk("lit_rs_vec_end", Vec_count, 1);
    chk("lit_rs_pass", Pass, 1);

    // Reset in the middle of a run.
    start(16'd2);
    drv(1'b1, 16'hAAAA, 16'h5555, 1'b0, 16'h0000, 1'b0);
    Reset_n = 1'b0;
    idle();
    Reset_n = 1'b1;
    chk("lit_mr_err",   Err_count, 0);
    chk("lit_mr_fv",    Fail_valid, 0);
    chk("lit_mr_done",  Done, 0);
    chk("lit_mr_ready", In_ready, 0);
    idle();
    chk("lit_mr_vec", Vec_count, 0);
    start(16'd1);
    drv(1'b1, 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1);
    idle();
    chk("lit_mr_pass", Pass, 1);
    chk("lit_mr_vec_end", Vec_count, 1);

    @(negedge Clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
